instr_stream_encoder: RTL and testbench

Encodes a stream of symbolic instruction records into 32-bit machine words and writes them to instruction memory at consecutive word addresses. It is the inverse of the control decoder: it uses the same opcode map, so words it produces decode to the intended control signals. It sits between a testbench or boot sequencer and the instruction-memory write port.

---
 rtl/instr_stream_encoder_pkg.sv | 56 +++++
 rtl/instr_word_encoder.sv | 41 ++++
 rtl/instr_stream_encoder.sv | 135 +++++++++++++
 tb/tb_instr_stream_encoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_encoder_pkg.sv
// Shared definitions for the instruction stream encoder.
// Holds the opcode map (same values the control decoder matches on), the
// record kind codes, instruction field widths and the session FSM states.
package instr_stream_encoder_pkg;

  localparam int WORD_W   = 32;
  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;
  localparam int KIND_W   = 3;

  typedef enum logic [KIND_W-1:0] {
    KIND_R    = 3'd0,
    KIND_ADDI = 3'd1,
    KIND_LW   = 3'd2,
    KIND_SW   = 3'd3,
    KIND_BEQ  = 3'd4,
    KIND_BNE  = 3'd5,
    KIND_J    = 3'd6,
    KIND_JAL  = 3'd7
  } kind_e;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001001;
  localparam logic [OP_W-1:0] OP_LW   = 6'b101100;
  localparam logic [OP_W-1:0] OP_SW   = 6'b100100;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000110;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_J    = 6'b000111;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [OP_W-1:0] opcode_of(kind_e kind);
    logic [OP_W-1:0] op;
    unique case (kind)
      KIND_R:    op = OP_R;
      KIND_ADDI: op = OP_ADDI;
      KIND_LW:   op = OP_LW;
      KIND_SW:   op = OP_SW;
      KIND_BEQ:  op = OP_BEQ;
      KIND_BNE:  op = OP_BNE;
      KIND_J:    op = OP_J;
      default:   op = OP_JAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational encoder: record kind plus fields -> 32-bit machine word.
// Ports:
//   kind_i                      record kind (R, addi, lw, sw, beq, bne, j, jal)
//   rs_i, rt_i, rd_i, shamt_i   register / shift fields
//   funct_i                     R-type function field
//   imm_i                       I-type immediate (branch offsets pass through as-is)
//   target_i                    J-type target field
//   word_o                      encoded instruction word
// Fields that the selected format does not use are ignored.
module instr_word_encoder
  import instr_stream_encoder_pkg::*;
(
  input  logic [KIND_W-1:0]   kind_i,
  input  logic [REG_W-1:0]    rs_i,
  input  logic [REG_W-1:0]    rt_i,
  input  logic [REG_W-1:0]    rd_i,
  input  logic [SHAMT_W-1:0]  shamt_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  input  logic [IMM_W-1:0]    imm_i,
  input  logic [TARGET_W-1:0] target_i,
  output logic [WORD_W-1:0]   word_o
);

  kind_e           kind;
  logic [OP_W-1:0] op;

  assign kind = kind_e'(kind_i);
  assign op   = opcode_of(kind);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    word_o = '0;
    unique case (kind)
      KIND_R:          word_o = {op, rs_i, rt_i, rd_i, shamt_i, funct_i};
      KIND_J, KIND_JAL: word_o = {op, target_i};
      default:         word_o = {op, rs_i, rt_i, imm_i};
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder: accepts symbolic instruction records over a
// valid/ready handshake, encodes each to a 32-bit word and writes it to
// instruction memory at consecutive word addresses starting at a base.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, base_addr_i  open a session at base_addr_i (only when idle)
//   in_valid_i/in_ready_o record handshake; kind_i and field inputs; last_i
//   mem_we_o/addr/wdata   registered memory write port
//   busy_o                session active; done_o one-cycle end-of-session pulse
//   count_o               words written in the current/last session
//   err_o                 sticky: session cut short because the address ran out
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [KIND_W-1:0]   kind_i,
  input  logic [REG_W-1:0]    rs_i,
  input  logic [REG_W-1:0]    rt_i,
  input  logic [REG_W-1:0]    rd_i,
  input  logic [SHAMT_W-1:0]  shamt_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  input  logic [IMM_W-1:0]    imm_i,
  input  logic [TARGET_W-1:0] target_i,
  input  logic                last_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [WORD_W-1:0]   mem_wdata_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [ADDR_W:0]     count_o,
  output logic                err_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [WORD_W-1:0]   enc_word;
  logic                accept;
  logic                at_top;

  instr_word_encoder u_enc (
    .kind_i   (kind_i),
    .rs_i     (rs_i),
    .rt_i     (rt_i),
    .rd_i     (rd_i),
    .shamt_i  (shamt_i),
    .funct_i  (funct_i),
    .imm_i    (imm_i),
    .target_i (target_i),
    .word_o   (enc_word)
  );

  assign accept = (state_q == ST_LOAD) && in_valid_i;
  assign at_top = (addr_q == '1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          addr_d  = base_addr_i;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = enc_word;
          addr_d      = addr_q + ADDR_ONE;
          count_d     = count_q + CNT_ONE;
          // The last address ends the session even without last_i, so the
          // address never wraps; an unfinished stream is flagged instead.
          if (last_i || at_top) state_d = ST_DRAIN;
          if (at_top && !last_i) err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready_o  = (state_q == ST_LOAD);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DRAIN);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder. An 8-bit-address instance
// carries the main scenarios; a 4-bit-address instance shares the stimulus
// and is used for the address-exhaustion scenario.
module tb_instr_stream_encoder;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0, in_valid = 1'b0, last = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [2:0]  kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  logic        ready, we, busy, done, err;
  logic [7:0]  maddr;
  logic [31:0] wdata;
  logic [8:0]  count;
  logic        s_ready, s_we, s_busy, s_done, s_err;
  logic [3:0]  s_maddr;
  logic [31:0] s_wdata;
  logic [4:0]  s_count;

  int checks = 0;
  int errors = 0;
  rec_t recs[$];

  always #5 clk = ~clk;

  instr_stream_encoder #(.ADDR_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
    .in_valid_i(in_valid), .in_ready_o(ready), .kind_i(kind),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
    .imm_i(imm), .target_i(target), .last_i(last),
    .mem_we_o(we), .mem_addr_o(maddr), .mem_wdata_o(wdata),
    .busy_o(busy), .done_o(done), .count_o(count), .err_o(err)
  );

  instr_stream_encoder #(.ADDR_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr[3:0]),
    .in_valid_i(in_valid), .in_ready_o(s_ready), .kind_i(kind),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
    .imm_i(imm), .target_i(target), .last_i(last),
    .mem_we_o(s_we), .mem_addr_o(s_maddr), .mem_wdata_o(s_wdata),
    .busy_o(s_busy), .done_o(s_done), .count_o(s_count), .err_o(s_err)
  );

  // Reference encoding: opcode table and field placement by arithmetic.
  function automatic int unsigned opc(logic [2:0] k);
    case (k)
      3'd0: return 0;   3'd1: return 9;  3'd2: return 44; 3'd3: return 36;
      3'd4: return 6;   3'd5: return 5;  3'd6: return 7;  default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] model_word(rec_t r);
    int unsigned w;
    w = opc(r.kind) * 32'd67108864;
    if (r.kind == 3'd0)
      w = w + r.rs * 32'd2097152 + r.rt * 32'd65536 + r.rd * 32'd2048 + r.shamt * 32'd64 + r.funct;
    else if (r.kind >= 3'd6)
      w = w + r.target;
    else
      w = w + r.rs * 32'd2097152 + r.rt * 32'd65536 + r.imm;
    return w;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.kind = 3'($urandom); r.rs = 5'($urandom); r.rt = 5'($urandom);
    r.rd = 5'($urandom); r.shamt = 5'($urandom); r.funct = 6'($urandom);
    r.imm = 16'($urandom); r.target = 26'($urandom);
    return r;
  endfunction

  function automatic rec_t mk(logic [2:0] k, logic [4:0] a, logic [4:0] b, logic [15:0] i, logic [25:0] t);
    rec_t r;
    r = '{kind: k, rs: a, rt: b, rd: 5'd0, shamt: 5'd0, funct: 6'd0, imm: i, target: t};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rec(input rec_t r, input logic lst, input logic v);
    kind = r.kind; rs = r.rs; rt = r.rt; rd = r.rd; shamt = r.shamt;
    funct = r.funct; imm = r.imm; target = r.target; last = lst; in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_rec(rand_rec(), 1'($urandom), 1'($urandom));
      start = 1'b1; base_addr = 8'($urandom);
      step();
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset/ready got %b exp 0", ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset/we got %b exp 0", we); end
    checks++; if (maddr !== 8'h00) begin errors++; $display("FAIL reset/addr got %h exp 00", maddr); end
    checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset/wdata got %h exp 0", wdata); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset/busy_done_err got %b exp 000", {busy, done, err}); end
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL reset/count got %0d exp 0", count); end
    checks++; if ({s_ready, s_we, s_busy, s_done, s_err} !== 5'b0) begin errors++; $display("FAIL reset/small_flags got %b exp 00000", {s_ready, s_we, s_busy, s_done, s_err}); end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();
    checks++; if ({busy, ready} !== 2'b00) begin errors++; $display("FAIL reset/idle_after got %b exp 00", {busy, ready}); end
  endtask

  task automatic test_single_r();
    rec_t r;
    r = '{kind: 3'd0, rs: 5'd1, rt: 5'd2, rd: 5'd3, shamt: 5'd0, funct: 6'h20, imm: 16'hBEEF, target: 26'h0};
    start = 1'b1; base_addr = 8'h10;
    step();
    start = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single/ready got %b exp 1", ready); end
    drive_rec(r, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL single/we got %b exp 1", we); end
    checks++; if (maddr !== 8'h10) begin errors++; $display("FAIL single/addr got %h exp 10", maddr); end
    checks++; if (wdata !== model_word(r)) begin errors++; $display("FAIL single/data got %h exp %h", wdata, model_word(r)); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single/done got %b exp 1", done); end
    checks++; if (count !== 9'd1) begin errors++; $display("FAIL single/count got %0d exp 1", count); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single/ready_drain got %b exp 0", ready); end
    step();
    checks++; if ({busy, done, we} !== 3'b000) begin errors++; $display("FAIL single/end got %b exp 000", {busy, done, we}); end
    checks++; if (maddr !== 8'h10 || wdata !== model_word(r)) begin errors++; $display("FAIL single/hold got %h:%h exp 10:%h", maddr, wdata, model_word(r)); end
  endtask

  // Runs one session over recs[]. vprob is the percentage chance in_valid is
  // high per cycle; stall_at >= 0 instead forces a 3-cycle gap before that
  // record. start_i is pulsed randomly while busy and must be ignored.
  task automatic run_session(input string name, input logic [7:0] base, input int vprob, input int stall_at);
    int n, nwr, sent, cyc, gap;
    logic v;
    logic [7:0] last_addr;
    logic [31:0] last_data;
    logic exp_err;
    n = recs.size();
    nwr = (n < 256 - int'(base)) ? n : 256 - int'(base);
    exp_err = (nwr < n);
    in_valid = 1'b0; start = 1'b1; base_addr = base;
    step();
    start = 1'b0;
    checks++; if ({busy, ready, err} !== 3'b110) begin errors++; $display("FAIL %s/open got %b exp 110", name, {busy, ready, err}); end
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL %s/count0 got %0d exp 0", name, count); end
    sent = 0; cyc = 0; gap = 0; last_addr = '0; last_data = '0;
    while (sent < nwr && cyc < 2000) begin
      if (stall_at >= 0) v = !(sent == stall_at && gap < 3);
      else v = ($urandom_range(0, 99) < vprob);
      if (!v) gap++;
      drive_rec(recs[sent], sent == n - 1, v);
      start = ($urandom_range(0, 3) == 0); base_addr = 8'($urandom);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s/ready[%0d] got %b exp 1", name, sent, ready); end
      step();
      cyc++;
      if (v) begin
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL %s/we[%0d] got %b exp 1", name, sent, we); end
        checks++; if (maddr !== 8'(int'(base) + sent)) begin errors++; $display("FAIL %s/addr[%0d] got %h exp %h", name, sent, maddr, 8'(int'(base) + sent)); end
        checks++; if (wdata !== model_word(recs[sent])) begin errors++; $display("FAIL %s/data[%0d] got %h exp %h", name, sent, wdata, model_word(recs[sent])); end
        checks++; if (count !== 9'(sent + 1)) begin errors++; $display("FAIL %s/count[%0d] got %0d exp %0d", name, sent, count, sent + 1); end
        checks++; if (done !== (sent + 1 == nwr)) begin errors++; $display("FAIL %s/done[%0d] got %b exp %b", name, sent, done, sent + 1 == nwr); end
        last_addr = 8'(int'(base) + sent); last_data = model_word(recs[sent]);
        sent++;
      end else begin
        checks++; if ({we, done} !== 2'b00) begin errors++; $display("FAIL %s/idle_cycle[%0d] got %b exp 00", name, sent, {we, done}); end
        if (sent > 0) begin
          checks++; if (maddr !== last_addr || wdata !== last_data) begin errors++; $display("FAIL %s/hold[%0d] got %h:%h exp %h:%h", name, sent, maddr, wdata, last_addr, last_data); end
        end
      end
    end
    if (sent < nwr) begin
      checks++; errors++;
      $display("FAIL %s/timeout got %0d writes exp %0d", name, sent, nwr);
    end
    in_valid = 1'b0; start = 1'b0;
    step();
    checks++; if ({busy, ready, done, we} !== 4'b0000) begin errors++; $display("FAIL %s/close got %b exp 0000", name, {busy, ready, done, we}); end
    checks++; if (count !== 9'(nwr)) begin errors++; $display("FAIL %s/count_end got %0d exp %0d", name, count, nwr); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL %s/err got %b exp %b", name, err, exp_err); end
  endtask

  task automatic test_back_to_back();
    recs.delete();
    recs.push_back(mk(3'd1, 5'd0, 5'd8, 16'd5, 26'h0));
    recs.push_back(mk(3'd2, 5'd8, 5'd9, 16'd4, 26'h0));
    recs.push_back(mk(3'd6, 5'd0, 5'd0, 16'd0, 26'h40));
    recs.push_back(mk(3'd7, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF));
    run_session("b2b", 8'h80, 100, -1);
  endtask

  task automatic test_stall();
    recs.delete();
    for (int i = 0; i < 5; i++) recs.push_back(rand_rec());
    run_session("stall", 8'h40, 100, 2);
  endtask

  task automatic test_random_sessions();
    for (int k = 0; k < 6; k++) begin
      recs.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) recs.push_back(rand_rec());
      run_session("rand", 8'($urandom), 70, -1);
    end
    recs.delete();
    for (int i = 0; i < 8; i++) recs.push_back(rand_rec());
    run_session("ovf8", 8'hFC, 80, -1);
  endtask

  task automatic test_overflow();
    rec_t r0, r1, r2, r3;
    r0 = rand_rec(); r1 = rand_rec(); r2 = rand_rec(); r3 = rand_rec();
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    step();
    rst = 1'b0; start = 1'b1; base_addr = 8'h0E;
    step();
    start = 1'b0;
    drive_rec(r0, 1'b0, 1'b1);
    step();
    checks++; if ({s_we, s_maddr, s_done, s_ready, s_err} !== {1'b1, 4'hE, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL ovf/first got we%b a%h d%b r%b e%b exp we1 aE d0 r1 e0", s_we, s_maddr, s_done, s_ready, s_err); end
    checks++; if (s_wdata !== model_word(r0)) begin errors++; $display("FAIL ovf/data0 got %h exp %h", s_wdata, model_word(r0)); end
    drive_rec(r1, 1'b0, 1'b1);
    step();
    checks++; if ({s_we, s_maddr, s_done, s_ready, s_err} !== {1'b1, 4'hF, 1'b1, 1'b0, 1'b1}) begin errors++; $display("FAIL ovf/second got we%b a%h d%b r%b e%b exp we1 aF d1 r0 e1", s_we, s_maddr, s_done, s_ready, s_err); end
    checks++; if (s_count !== 5'd2) begin errors++; $display("FAIL ovf/count got %0d exp 2", s_count); end
    drive_rec(r2, 1'b0, 1'b1);
    step();
    checks++; if ({s_we, s_busy, s_err, s_maddr} !== {1'b0, 1'b0, 1'b1, 4'hF}) begin errors++; $display("FAIL ovf/after got we%b b%b e%b a%h exp we0 b0 e1 aF", s_we, s_busy, s_err, s_maddr); end
    checks++; if (s_count !== 5'd2) begin errors++; $display("FAIL ovf/count_hold got %0d exp 2", s_count); end
    in_valid = 1'b0; start = 1'b1; base_addr = 8'h03;
    step();
    start = 1'b0;
    checks++; if ({s_err, s_busy, s_count} !== {1'b0, 1'b1, 5'd0}) begin errors++; $display("FAIL ovf/restart got e%b b%b c%0d exp e0 b1 c0", s_err, s_busy, s_count); end
    drive_rec(r3, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    checks++; if ({s_we, s_maddr, s_done} !== {1'b1, 4'h3, 1'b1}) begin errors++; $display("FAIL ovf/restart_write got we%b a%h d%b exp we1 a3 d1", s_we, s_maddr, s_done); end
    step();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    step();
    rst = 1'b0; start = 1'b1; base_addr = 8'h20;
    step();
    start = 1'b0;
    drive_rec(rand_rec(), 1'b0, 1'b1);
    step();
    checks++; if ({we, maddr} !== {1'b1, 8'h20}) begin errors++; $display("FAIL rmid/accepted got we%b a%h exp we1 a20", we, maddr); end
    rst = 1'b1;
    drive_rec(rand_rec(), 1'b0, 1'b1);
    step();
    checks++; if ({we, busy, ready, done} !== 4'b0000) begin errors++; $display("FAIL rmid/flags got %b exp 0000", {we, busy, ready, done}); end
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL rmid/count got %0d exp 0", count); end
    rst = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if ({we, busy, ready} !== 3'b000) begin errors++; $display("FAIL rmid/idle got %b exp 000", {we, busy, ready}); end
  endtask

  initial begin
    test_reset();
    test_single_r();
    test_back_to_back();
    test_stall();
    test_random_sessions();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
